// File: rtl/store_drain_buffer_pkg.sv
// store_drain_buffer_pkg: shared entry layout, drain states and widths for the store drain buffer.
package store_drain_buffer_pkg;
  localparam int SDB_ADDR_WIDTH = 32;
  localparam int SDB_WORD_WIDTH = 32;
  localparam int STROBE_WIDTH = SDB_WORD_WIDTH / 8;
  typedef struct packed {
    logic [SDB_ADDR_WIDTH-3:0] addr;
    logic [STROBE_WIDTH-1:0] strobe;
    logic [SDB_WORD_WIDTH-1:0] data;
  } sdb_entry_t;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} sdb_state_t;
endpackage

// File: rtl/sdb_storage.sv
// sdb_storage: entry register array with tail write port, head read port and per-slot address compare.
module sdb_storage
  import store_drain_buffer_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  localparam int IW = $clog2(NUM_ENTRIES)
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [IW-1:0]             wr_idx,
  input  sdb_entry_t                wr_entry,
  input  logic [IW-1:0]             rd_idx,
  output sdb_entry_t                rd_entry,
  input  logic [SDB_ADDR_WIDTH-3:0] cmp_addr,
  output logic [NUM_ENTRIES-1:0]    match
);
  sdb_entry_t mem [NUM_ENTRIES];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_idx] <= wr_entry;
  assign rd_entry = mem[rd_idx];
  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_cmp
    assign match[i] = mem[i].addr == cmp_addr;
  end
endmodule

// File: rtl/store_drain_buffer.sv
// store_drain_buffer: in-order store write buffer draining to the memory bus, with load hazard lookup.
module store_drain_buffer
  import store_drain_buffer_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_valid,
  output logic                    push_ready,
  input  logic [ADDR_WIDTH-1:0]   push_addr,
  input  logic [STROBE_WIDTH-1:0] push_strobe,
  input  logic [WORD_WIDTH-1:0]   push_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [STROBE_WIDTH-1:0] m_strobe,
  output logic [WORD_WIDTH-1:0]   m_data,
  input  logic                    m_done,
  input  logic [ADDR_WIDTH-1:0]   lookup_addr,
  output logic                    lookup_hit,
  output logic                    empty,
  output logic                    full
);
  localparam int PW = $clog2(NUM_ENTRIES);
  logic [PW:0] head, tail, count, head_nxt, tail_nxt;
  sdb_state_t state, state_nxt;
  sdb_entry_t wr_entry, head_entry;
  logic [NUM_ENTRIES-1:0] match, occ;
  logic push, pop, unused_bits;
  assign full = head[PW] != tail[PW] && head[PW-1:0] == tail[PW-1:0];
  assign empty = head == tail;
  assign push_ready = !full;
  assign push = push_valid && push_ready;
  assign pop = state == WAIT && m_done;
  assign count = tail - head;
  assign head_nxt = head + (PW+1)'(pop);
  assign tail_nxt = tail + (PW+1)'(push);
  assign wr_entry = '{addr: push_addr[ADDR_WIDTH-1:2], strobe: push_strobe, data: push_data};
  assign unused_bits = ^{push_addr[1:0], lookup_addr[1:0]};
  sdb_storage #(.NUM_ENTRIES(NUM_ENTRIES)) u_storage (
    .clk(clk),
    .wr_en(push),
    .wr_idx(tail[PW-1:0]),
    .wr_entry(wr_entry),
    .rd_idx(head[PW-1:0]),
    .rd_entry(head_entry),
    .cmp_addr(lookup_addr[ADDR_WIDTH-1:2]),
    .match(match)
  );
  // a slot is occupied when its distance from head is below the occupancy count
  always_comb begin
    occ = '0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      occ[i] = {1'b0, PW'(i) - head[PW-1:0]} < count;
  end
  assign lookup_hit = |(match & occ);
  // next state after a pop accounts for a push landing on the same edge
  assign state_nxt = state == IDLE ? (empty ? IDLE : REQ) :
                     state == REQ  ? (m_ready ? WAIT : REQ) :
                     !m_done ? WAIT : (tail_nxt != head_nxt ? REQ : IDLE);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      head <= '0;
      tail <= '0;
      state <= IDLE;
    end else begin
      head <= head_nxt;
      tail <= tail_nxt;
      state <= state_nxt;
    end
  assign m_valid = state == REQ;
  assign m_addr = {head_entry.addr, 2'b00};
  assign m_strobe = head_entry.strobe;
  assign m_data = head_entry.data;
endmodule

// File: tb/tb_store_drain_buffer.sv
// tb_store_drain_buffer: directed self-checking bench for the store drain buffer.
module tb_store_drain_buffer;
  logic clk = 0, reset = 1;
  logic push_valid = 0, push_ready;
  logic [31:0] push_addr = 0, push_data = 0;
  logic [3:0] push_strobe = 0;
  logic m_valid, m_ready = 0, m_done = 0;
  logic [31:0] m_addr, m_data;
  logic [3:0] m_strobe;
  logic [31:0] lookup_addr = 0;
  logic lookup_hit, empty, full;
  int n_checks = 0, n_fails = 0;
  logic [31:0] q[$];
  store_drain_buffer dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_ready(push_ready), .push_addr(push_addr),
    .push_strobe(push_strobe), .push_data(push_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_strobe(m_strobe),
    .m_data(m_data), .m_done(m_done),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .empty(empty), .full(full)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    push_valid = 1;
    push_addr = a;
    push_strobe = s;
    push_data = d;
  endtask
  initial begin
    int pushed, got, cyc;
    logic was_req, acc;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_push_ready", push_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_hit", lookup_hit, 0);
    step();
    reset = 0;
    // single store
    push(32'h1000_0004, 4'b0011, 32'hDEAD_BEEF);
    step();
    push_valid = 0;
    chk("t1_not_yet", m_valid, 0);
    chk("t1_empty0", empty, 0);
    step();
    chk("t1_m_valid", m_valid, 1);
    chk("t1_m_addr", m_addr, 32'h1000_0004);
    chk("t1_m_strobe", m_strobe, 4'b0011);
    chk("t1_m_data", m_data, 32'hDEAD_BEEF);
    m_ready = 1;
    step();
    m_ready = 0;
    chk("t1_m_valid_drop", m_valid, 0);
    step();
    step();
    m_done = 1;
    step();
    m_done = 0;
    chk("t1_empty", empty, 1);
    chk("t1_idle", m_valid, 0);
    // fill to capacity with the bus stalled
    for (int i = 0; i < 8; i++) begin
      push(32'h0000_0100 + 32'(4 * i), 4'hF, 32'hC0DE_0000 + 32'(i));
      step();
    end
    push_valid = 0;
    chk("t2_full", full, 1);
    chk("t2_push_ready", push_ready, 0);
    push(32'h0000_0BAD, 4'hF, 32'h0000_0BAD);
    step();
    push_valid = 0;
    chk("t2_still_full", full, 1);
    for (int i = 0; i < 8; i++) begin
      chk("t2_m_valid", m_valid, 1);
      chk("t2_m_addr", m_addr, 32'h0000_0100 + 32'(4 * i));
      chk("t2_m_data", m_data, 32'hC0DE_0000 + 32'(i));
      m_ready = 1;
      step();
      m_ready = 0;
      m_done = 1;
      step();
      m_done = 0;
    end
    chk("t2_empty", empty, 1);
    chk("t2_idle", m_valid, 0);
    // wrap: 20 stores streamed through with drains interleaved
    pushed = 0;
    got = 0;
    was_req = 0;
    for (cyc = 0; cyc < 400 && got < 20; cyc++) begin
      push_valid = pushed < 20;
      push_addr = 32'h3000_0000 + 32'(4 * pushed);
      push_data = 32'hA500_0000 + 32'(pushed);
      push_strobe = 4'hF;
      m_ready = 1;
      m_done = was_req;
      acc = push_valid && push_ready;
      if (m_valid) begin
        if (q.size() == 0) chk("wrap_spurious", m_valid, 0);
        else begin
          chk("wrap_data", m_data, q.pop_front());
          got++;
        end
      end
      if (acc) q.push_back(push_data);
      was_req = m_valid;
      step();
      if (acc) pushed++;
    end
    push_valid = 0;
    m_ready = 0;
    chk("wrap_count", 64'(got), 20);
    m_done = 1;
    step();
    m_done = 0;
    chk("wrap_empty", empty, 1);
    // hazard lookup
    push(32'h2000_0008, 4'hF, 32'h1111_2222);
    lookup_addr = 32'h2000_0008;
    #1;
    chk("t4_same_cycle_push", lookup_hit, 0);
    step();
    push_valid = 0;
    lookup_addr = 32'h2000_000B;
    #1;
    chk("t4_hit_b", lookup_hit, 1);
    lookup_addr = 32'h2000_000C;
    #1;
    chk("t4_miss_c", lookup_hit, 0);
    step();
    m_ready = 1;
    step();
    m_ready = 0;
    lookup_addr = 32'h2000_0008;
    #1;
    chk("t4_hit_inflight", lookup_hit, 1);
    m_done = 1;
    step();
    m_done = 0;
    lookup_addr = 32'h2000_000B;
    #1;
    chk("t4_after_b", lookup_hit, 0);
    lookup_addr = 32'h2000_000C;
    #1;
    chk("t4_after_c", lookup_hit, 0);
    // simultaneous pop and push
    push(32'h4000_0000, 4'h1, 32'h0000_00AA);
    step();
    push_valid = 0;
    step();
    m_ready = 1;
    step();
    m_ready = 0;
    m_done = 1;
    push(32'h4000_0010, 4'h2, 32'h0000_BB00);
    step();
    m_done = 0;
    push_valid = 0;
    chk("t5_m_valid", m_valid, 1);
    chk("t5_m_addr", m_addr, 32'h4000_0010);
    chk("t5_empty", empty, 0);
    lookup_addr = 32'h4000_0000;
    #1;
    chk("t5_old_gone", lookup_hit, 0);
    lookup_addr = 32'h4000_0010;
    #1;
    chk("t5_new_hit", lookup_hit, 1);
    m_ready = 1;
    step();
    m_ready = 0;
    m_done = 1;
    step();
    m_done = 0;
    chk("t5_empty_end", empty, 1);
    // asynchronous reset while requesting
    for (int i = 0; i < 3; i++) begin
      push(32'h5000_0000 + 32'(4 * i), 4'hF, 32'(i));
      step();
    end
    push_valid = 0;
    chk("t6_req", m_valid, 1);
    #3 reset = 1;
    #1;
    chk("t6_async_m_valid", m_valid, 0);
    chk("t6_async_empty", empty, 1);
    @(posedge clk);
    #1 reset = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_quiet", m_valid, 0);
    end
    push(32'h6000_0020, 4'hF, 32'h7777_7777);
    step();
    push_valid = 0;
    step();
    chk("t6_new_valid", m_valid, 1);
    chk("t6_new_addr", m_addr, 32'h6000_0020);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
